alu_operand_sequencer: RTL and testbench

Host-side driver for the 8-bit ALU's byte-wide pin interface. It accepts an (opcode, A, B) request over a valid/ready handshake and serialises a 3-byte frame onto the ALU input pins. It then waits a fixed result latency, samples the ALU output pins, and returns the result over a valid/ready response channel. It sits between the on-chip controller and the ALU, sharing the ALU's clk/rst/ena.

---
 rtl/alu_operand_sequencer.sv | 115 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Host-side driver for the 8-bit ALU pin interface. Takes an (op, A, B)
//   request, serialises a 3-byte frame (header, A, B) onto alu_in, waits
//   RESULT_LATENCY cycles, samples alu_out and offers it as a response.
//
// Ports:
//   clk, rst, ena         clock, synchronous active-high reset, block enable
//   req_valid/req_ready   request handshake; req_op/req_a/req_b payload
//   alu_in                registered drive of ALU IN7..IN0
//   alu_out               ALU OUT7..OUT0, sampled at the end of the latency
//   rsp_valid/rsp_ready   response handshake; rsp_data captured result
//   busy                  high whenever a frame or response is in progress
module alu_operand_sequencer #(
   parameter int unsigned RESULT_LATENCY = 2,
   parameter logic [7:0]  IDLE_BYTE      = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_op,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   output logic [7:0] alu_in,
   input  logic [7:0] alu_out,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_OPA,
      S_OPB,
      S_WAIT,
      S_RESP
   } state_t;

   // Counter is loaded with LATENCY-1 so that the capture happens on the
   // edge closing the RESULT_LATENCY-th cycle after the B byte.
   localparam logic [3:0] CNT_LOAD = 4'(RESULT_LATENCY - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [7:0] a_q;
   logic [7:0] b_q;

   assign req_ready = ena & (state == S_IDLE);

   // alu_in is assigned together with the state transition, so the byte on
   // the pins always belongs to the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         alu_in    <= IDLE_BYTE;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         busy      <= 1'b0;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
      end else if (ena) begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  a_q    <= req_a;
                  b_q    <= req_b;
                  alu_in <= {1'b1, 3'b000, req_op};
                  busy   <= 1'b1;
                  state  <= S_HDR;
               end
            end
            S_HDR: begin
               alu_in <= a_q;
               state  <= S_OPA;
            end
            S_OPA: begin
               alu_in <= b_q;
               state  <= S_OPB;
            end
            S_OPB: begin
               alu_in <= IDLE_BYTE;
               cnt    <= CNT_LOAD;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  rsp_data  <= alu_out;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               alu_in    <= IDLE_BYTE;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer: two instances (RESULT_LATENCY 2 and 1),
// a pin-level ALU model per instance and a transaction-level reference.
module tb_alu_operand_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, ena;
   logic [3:0] req_op;
   logic [7:0] req_a, req_b;
   logic [1:0] rv, rr;
   logic [1:0][7:0] aout;

   logic       rdy0, rdy1, vld0, vld1, bsy0, bsy1;
   logic [7:0] ain0, ain1, rd0, rd1;
   logic [1:0] rdy, vld, bsy;
   logic [1:0][7:0] ain, rdata;
   assign rdy   = {rdy1, rdy0};
   assign vld   = {vld1, vld0};
   assign bsy   = {bsy1, bsy0};
   assign ain   = {ain1, ain0};
   assign rdata = {rd1, rd0};

   alu_operand_sequencer #(.RESULT_LATENCY(2), .IDLE_BYTE(8'h00)) dut (
      .clk(clk), .rst(rst), .ena(ena),
      .req_valid(rv[0]), .req_ready(rdy0),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_in(ain0), .alu_out(aout[0]),
      .rsp_valid(vld0), .rsp_ready(rr[0]), .rsp_data(rd0),
      .busy(bsy0)
   );

   alu_operand_sequencer #(.RESULT_LATENCY(1), .IDLE_BYTE(8'h00)) dut1 (
      .clk(clk), .rst(rst), .ena(ena),
      .req_valid(rv[1]), .req_ready(rdy1),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_in(ain1), .alu_out(aout[1]),
      .rsp_valid(vld1), .rsp_ready(rr[1]), .rsp_data(rd1),
      .busy(bsy1)
   );

   int checks = 0;
   int errors = 0;

   // ALU model state (pin level) and reference transaction state, per DUT
   int         lat [2] = '{2, 1};
   int         ph  [2] = '{0, 0};
   int         w   [2] = '{0, 0};
   logic [3:0] m_op[2] = '{4'h0, 4'h0};
   logic [7:0] m_a [2] = '{8'h00, 8'h00};
   logic [7:0] m_b [2] = '{8'h00, 8'h00};
   int         rs  [2] = '{0, 0};   // 0 idle, 1 frame/wait, 2 response held
   int         el  [2] = '{0, 0};   // enabled edges since accept
   logic [7:0] x_hdr[2], x_a[2], x_b[2], x_res[2];
   logic [7:0] x_data[2] = '{8'h00, 8'h00};

   function automatic logic [7:0] alu_f(logic [3:0] op, logic [7:0] a, logic [7:0] b);
      case (op)
         4'h0, 4'h3: return a + b;
         4'h1:       return a - b;
         4'h2:       return a & b;
         4'h4:       return a | b;
         4'h5:       return a ^ b;
         default:    return a + b + {4'h0, op};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      logic       p_rst, p_ena;
      logic [1:0] p_rv, p_rr;
      logic [1:0][7:0] p_in;
      logic [7:0] r, exp_in;
      p_rst = rst; p_ena = ena; p_rv = rv; p_rr = rr; p_in = ain;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         // ALU: decode frame from the pins, present result only in the
         // cycle that ends with the sampling edge, garbage otherwise
         if (p_rst) begin
            ph[d] = 0; w[d] = 0;
         end else if (p_ena) begin
            case (ph[d])
               0: if (p_in[d][7]) begin m_op[d] = p_in[d][3:0]; ph[d] = 1; end
               1: begin m_a[d] = p_in[d]; ph[d] = 2; end
               2: begin m_b[d] = p_in[d]; ph[d] = 3; w[d] = 0; end
               default: begin w[d]++; if (w[d] >= lat[d]) ph[d] = 0; end
            endcase
         end
         r = alu_f(m_op[d], m_a[d], m_b[d]);
         aout[d] = (ph[d] == 3 && w[d] == lat[d] - 1) ? r : ~r;

         // Reference: one outstanding transaction, response 3+L enabled
         // edges after the accept edge, released on an enabled rsp_ready
         if (p_rst) begin
            rs[d] = 0; x_data[d] = 8'h00;
         end else if (p_ena) begin
            case (rs[d])
               0: if (p_rv[d]) begin
                  rs[d] = 1; el[d] = 0;
                  x_hdr[d] = {4'h8, req_op}; x_a[d] = req_a; x_b[d] = req_b;
                  x_res[d] = alu_f(req_op, req_a, req_b);
               end
               1: begin
                  el[d]++;
                  if (el[d] == 3 + lat[d]) begin rs[d] = 2; x_data[d] = x_res[d]; end
               end
               default: if (p_rr[d]) rs[d] = 0;
            endcase
         end
         exp_in = 8'h00;
         if (rs[d] == 1) begin
            case (el[d])
               0: exp_in = x_hdr[d];
               1: exp_in = x_a[d];
               2: exp_in = x_b[d];
               default: exp_in = 8'h00;
            endcase
         end
         chk($sformatf("d%0d_alu_in", d), 32'(ain[d]), 32'(exp_in));
         chk($sformatf("d%0d_req_ready", d), 32'(rdy[d]), 32'(ena && rs[d] == 0));
         chk($sformatf("d%0d_rsp_valid", d), 32'(vld[d]), 32'(rs[d] == 2));
         chk($sformatf("d%0d_busy", d), 32'(bsy[d]), 32'(rs[d] != 0));
         chk($sformatf("d%0d_rsp_data", d), 32'(rdata[d]), 32'(x_data[d]));
      end
   endtask

   // Accept one request on DUT d and wait (bounded) for rsp_valid; cyc counts
   // the accept cycle as 1. s1..s4 are alu_in in the four cycles after accept.
   task automatic issue(input int d, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, output int cyc,
                        output logic [7:0] s1, output logic [7:0] s2,
                        output logic [7:0] s3, output logic [7:0] s4);
      req_op = op; req_a = a; req_b = b; rv[d] = 1'b1;
      chk($sformatf("issue_ready_d%0d", d), 32'(rdy[d]), 32'd1);
      tick();
      rv[d] = 1'b0;
      req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
      cyc = 1; s1 = ain[d]; s2 = 8'hxx; s3 = 8'hxx; s4 = 8'hxx;
      while (!vld[d] && cyc < 40) begin
         tick();
         cyc++;
         if (cyc == 2) s2 = ain[d];
         if (cyc == 3) s3 = ain[d];
         if (cyc == 4) s4 = ain[d];
      end
      if (!vld[d]) chk($sformatf("rsp_timeout_d%0d", d), 32'(vld[d]), 32'd1);
   endtask

   typedef struct {
      logic [3:0] op;
      logic [7:0] a, b, res;
   } vec_t;

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vec[5];
      int cyc, first, second;
      logic [7:0] s1, s2, s3, s4;
      logic any_v;

      vec[0] = '{op: 4'h0, a: 8'h12, b: 8'h34, res: 8'h46};
      vec[1] = '{op: 4'h1, a: 8'h50, b: 8'h20, res: 8'h30};
      vec[2] = '{op: 4'h2, a: 8'hF0, b: 8'h3C, res: 8'h30};
      vec[3] = '{op: 4'h5, a: 8'hAA, b: 8'hFF, res: 8'h55};
      vec[4] = '{op: 4'hF, a: 8'h10, b: 8'h20, res: 8'h3F};

      rst = 1'b1; ena = 1'b1; rv = '0; rr = '0;
      req_op = '0; req_a = '0; req_b = '0; aout = '0;
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();
      for (int d = 0; d < 2; d++) begin
         chk("reset_alu_in", 32'(ain[d]), 32'h00);
         chk("reset_req_ready", 32'(rdy[d]), 32'd1);
         chk("reset_rsp_valid", 32'(vld[d]), 32'd0);
         chk("reset_busy", 32'(bsy[d]), 32'd0);
         chk("reset_rsp_data", 32'(rdata[d]), 32'h00);
      end

      // table of single transactions on the default-latency instance
      for (int i = 0; i < 5; i++) begin
         issue(0, vec[i].op, vec[i].a, vec[i].b, cyc, s1, s2, s3, s4);
         chk($sformatf("vec%0d_hdr", i), 32'(s1), 32'({4'h8, vec[i].op}));
         chk($sformatf("vec%0d_a", i), 32'(s2), 32'(vec[i].a));
         chk($sformatf("vec%0d_b", i), 32'(s3), 32'(vec[i].b));
         chk($sformatf("vec%0d_idle", i), 32'(s4), 32'h00);
         chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'd6);
         chk($sformatf("vec%0d_data", i), 32'(rdata[0]), 32'(vec[i].res));
         rr[0] = 1'b1; tick(); rr[0] = 1'b0;
         chk($sformatf("vec%0d_released", i), 32'(vld[0]), 32'd0);
      end

      // response held with rsp_ready low, then immediate next accept
      issue(0, 4'h1, 8'h77, 8'h11, cyc, s1, s2, s3, s4);
      repeat (4) begin
         tick();
         chk("hold_valid", 32'(vld[0]), 32'd1);
         chk("hold_data", 32'(rdata[0]), 32'h66);
         chk("hold_ready", 32'(rdy[0]), 32'd0);
      end
      rr[0] = 1'b1; tick(); rr[0] = 1'b0;
      chk("hs_valid", 32'(vld[0]), 32'd0);
      chk("hs_ready", 32'(rdy[0]), 32'd1);
      issue(0, 4'h4, 8'h0F, 8'hF0, cyc, s1, s2, s3, s4);
      chk("next_data", 32'(rdata[0]), 32'hFF);
      chk("next_latency", 32'(cyc), 32'd6);
      rr[0] = 1'b1; tick(); rr[0] = 1'b0;

      // back-to-back accepts with rsp_ready held high
      rr[0] = 1'b1; rv[0] = 1'b1; req_op = 4'h0; req_a = 8'h01; req_b = 8'h02;
      first = -1; second = -1;
      for (int t = 0; t < 40 && second < 0; t++) begin
         if (rdy[0]) begin
            if (first < 0) first = t;
            else second = t;
         end
         tick();
      end
      rv[0] = 1'b0;
      chk("b2b_period", 32'(second - first), 32'd7);
      repeat (10) tick();
      rr[0] = 1'b0;

      // ena low for 3 cycles during the OPA cycle
      req_op = 4'h2; req_a = 8'hF0; req_b = 8'h3C; rv[0] = 1'b1;
      chk("ena_accept_ready", 32'(rdy[0]), 32'd1);
      tick(); rv[0] = 1'b0; cyc = 1;
      tick(); cyc++;
      chk("ena_opa", 32'(ain[0]), 32'hF0);
      ena = 1'b0;
      repeat (3) begin
         tick(); cyc++;
         chk("ena_hold_a", 32'(ain[0]), 32'hF0);
         chk("ena_ready_low", 32'(rdy[0]), 32'd0);
      end
      ena = 1'b1;
      tick(); cyc++;
      chk("ena_resume_b", 32'(ain[0]), 32'h3C);
      while (!vld[0] && cyc < 40) begin tick(); cyc++; end
      chk("ena_latency", 32'(cyc), 32'd9);
      chk("ena_data", 32'(rdata[0]), 32'h30);
      ena = 1'b0; rr[0] = 1'b1;
      repeat (2) begin
         tick();
         chk("ena_no_handshake", 32'(vld[0]), 32'd1);
      end
      ena = 1'b1;
      tick(); rr[0] = 1'b0;
      chk("ena_handshake", 32'(vld[0]), 32'd0);

      // reset during WAIT aborts the frame
      req_op = 4'h0; req_a = 8'h01; req_b = 8'h02; rv[0] = 1'b1;
      tick(); rv[0] = 1'b0;
      repeat (3) tick();
      chk("abort_in_wait_busy", 32'(bsy[0]), 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("abort_alu_in", 32'(ain[0]), 32'h00);
      chk("abort_valid", 32'(vld[0]), 32'd0);
      chk("abort_busy", 32'(bsy[0]), 32'd0);
      any_v = 1'b0;
      repeat (15) begin tick(); any_v |= vld[0]; end
      chk("abort_no_response", 32'(any_v), 32'd0);

      // RESULT_LATENCY=1 instance
      issue(1, 4'h3, 8'hFF, 8'h01, cyc, s1, s2, s3, s4);
      chk("l1_hdr", 32'(s1), 32'h83);
      chk("l1_latency", 32'(cyc), 32'd5);
      chk("l1_data", 32'(rdata[1]), 32'h00);
      rr[1] = 1'b1; tick(); rr[1] = 1'b0;

      // randomized traffic against the reference model
      for (int n = 0; n < 500; n++) begin
         rst    = ($urandom_range(0, 99) == 0);
         ena    = ($urandom_range(0, 9) != 0);
         rv     = 2'($urandom);
         rr     = 2'($urandom);
         req_op = 4'($urandom);
         req_a  = 8'($urandom);
         req_b  = 8'($urandom);
         tick();
      end
      rst = 1'b0; ena = 1'b1; rv = '0; rr = '0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
